axi_w_sequencer: RTL

Write-data sequencer for one master port of the AXI node. It stores the order in which the AW allocator granted write bursts in an internal ID FIFO. It then routes W beats from the owning target port to the master port, one complete burst at a time, and advances only on the accepted `wlast` beat. It connects directly to the AW allocator's push interface (`push_ID`, `ID`, `grant_FIFO_ID`) and is the only consumer of those IDs.

---
 rtl/axi_w_sequencer.sv | 88 ++++++++
 1 files changed

// File: rtl/axi_w_sequencer.sv
// axi_w_sequencer: routes W beats from the target port that owns the oldest AW grant to the master port.
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   wdata_i/wstrb_i/wlast_i/wuser_i    per-target-port W beat fields
//   wvalid_i / wready_o                per-target-port W handshake
//   wdata_o/wstrb_o/wlast_o/wuser_o    routed W beat toward the slave
//   wvalid_o / wready_i                routed W handshake
//   push_ID_i, ID_i                    AW allocator grant push, ID_i = {BIN, OH}
//   grant_FIFO_ID_o                    ID FIFO has room for a push
module axi_w_sequencer #(
   parameter int AXI_DATA_W  = 64,
   parameter int AXI_USER_W  = 6,
   parameter int N_TARG_PORT = 7,
   parameter int LOG_N_TARG  = $clog2(N_TARG_PORT),
   parameter int FIFO_DEPTH  = 8
) (
   input  logic                                          clk,
   input  logic                                          rst_n,
   input  logic [N_TARG_PORT-1:0][AXI_DATA_W-1:0]        wdata_i,
   input  logic [N_TARG_PORT-1:0][AXI_DATA_W/8-1:0]      wstrb_i,
   input  logic [N_TARG_PORT-1:0]                        wlast_i,
   input  logic [N_TARG_PORT-1:0][AXI_USER_W-1:0]        wuser_i,
   input  logic [N_TARG_PORT-1:0]                        wvalid_i,
   output logic [N_TARG_PORT-1:0]                        wready_o,
   output logic [AXI_DATA_W-1:0]                         wdata_o,
   output logic [AXI_DATA_W/8-1:0]                       wstrb_o,
   output logic                                          wlast_o,
   output logic [AXI_USER_W-1:0]                         wuser_o,
   output logic                                          wvalid_o,
   input  logic                                          wready_i,
   input  logic                                          push_ID_i,
   input  logic [LOG_N_TARG+N_TARG_PORT-1:0]             ID_i,
   output logic                                          grant_FIFO_ID_o
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int IW = LOG_N_TARG + N_TARG_PORT;
   typedef enum logic {EMPTY, ROUTE} state_t;
   state_t                 r_state, w_state_nxt;
   logic [IW-1:0]          r_mem [FIFO_DEPTH];
   logic [PW-1:0]          r_rd, r_wr;
   logic [CW-1:0]          r_count, w_count_nxt;
   logic [N_TARG_PORT-1:0] w_head_oh;
   logic                   w_push, w_pop;

   // grant depends only on the registered count, so no path from wready_i or push_ID_i
   assign grant_FIFO_ID_o = r_count != CW'(FIFO_DEPTH);
   assign w_push          = push_ID_i & grant_FIFO_ID_o;
   assign w_pop           = wvalid_o & wready_i & wlast_o;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_state <= EMPTY;
         r_count <= '0;
         r_rd    <= '0;
         r_wr    <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_count <= w_count_nxt;
         r_rd    <= r_rd + PW'(w_pop);
         r_wr    <= r_wr + PW'(w_push);
      end

   always_ff @(posedge clk)
      if (w_push) r_mem[r_wr] <= ID_i;

   always_comb begin
      w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
      w_state_nxt = (w_count_nxt == '0) ? EMPTY : ROUTE;
   end

   // AND-OR mux over the head OH; an empty FIFO forces every routed output to zero
   always_comb begin
      w_head_oh = (r_state == ROUTE) ? r_mem[r_rd][N_TARG_PORT-1:0] : '0;
      wdata_o   = '0;
      wstrb_o   = '0;
      wlast_o   = 1'b0;
      wuser_o   = '0;
      for (int i = 0; i < N_TARG_PORT; i++) begin
         wdata_o |= wdata_i[i] & {AXI_DATA_W{w_head_oh[i]}};
         wstrb_o |= wstrb_i[i] & {(AXI_DATA_W/8){w_head_oh[i]}};
         wuser_o |= wuser_i[i] & {AXI_USER_W{w_head_oh[i]}};
         wlast_o |= wlast_i[i] & w_head_oh[i];
      end
      wvalid_o = |(wvalid_i & w_head_oh);
      wready_o = w_head_oh & {N_TARG_PORT{wready_i}};
   end
endmodule
